// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and defaults for the master and slave blocks.
package spi_pkg;
   typedef enum logic {IDLE, ACTIVE} slave_state_t;
   localparam int DATA_W_DEF = 8;
   localparam logic [7:0] DUMMY_DEF = 8'hFF;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop pin synchronizer with rise/fall pulse detection.
module spi_pin_sync #(
   parameter int STAGES = 2,
   parameter logic INIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic prev;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= {STAGES{INIT}};
         prev <= INIT;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
      end
   assign q = sync[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with oversampled pins, rx strobe and a
// valid/ready tx shadow register feeding the miso shifter.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter logic [DATA_W-1:0] DUMMY = DATA_W'(DUMMY_DEF),
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              underrun,
   output logic              frame_abort,
   output logic              busy
);
   localparam int CW = $clog2(DATA_W);
   localparam int WW = $clog2(SYNC_STAGES + 1) + 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   slave_state_t state, state_nxt;
   logic sclk_level_unused, s_rise, s_fall, ss_q, ss_rise, ss_fall, mosi_q;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [WW-1:0] warm;
   logic armed, start, pending, word_done, shadow_full;
   logic [CW-1:0] bit_cnt;
   logic [DATA_W-1:0] rx_shift, tx_shift, shadow, next_word;

   spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_level_unused), .rise(s_rise), .fall(s_fall));
   spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
      .clk(clk), .rst(rst), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall));

   assign mosi_q = mosi_sync[SYNC_STAGES-1];
   // Only a fall seen after ss was observed high post-reset may open a frame.
   assign start = ss_fall & armed;
   assign next_word = shadow_full ? shadow : DUMMY;
   assign tx_ready = ~shadow_full;
   assign busy = state == ACTIVE;
   assign miso_oe = ~ss_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   always_comb
      state_nxt = state == IDLE ? (start ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mosi_sync <= '0;
         warm <= '0;
         armed <= 1'b0;
         bit_cnt <= '0;
         pending <= 1'b0;
         word_done <= 1'b0;
         rx_shift <= '0;
         tx_shift <= '0;
         shadow <= '0;
         shadow_full <= 1'b0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         frame_abort <= 1'b0;
         miso <= 1'b0;
      end else begin
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         if (warm != WW'(SYNC_STAGES)) warm <= warm + 1'b1;
         else if (ss_q) armed <= 1'b1;
         rx_valid <= word_done;
         word_done <= 1'b0;
         if (word_done) rx_data <= rx_shift;
         underrun <= 1'b0;
         frame_abort <= 1'b0;
         if (tx_valid && !shadow_full) begin
            shadow <= tx_data;
            shadow_full <= 1'b1;
         end
         if (state == IDLE) begin
            if (start) begin
               bit_cnt <= '0;
               pending <= 1'b0;
               tx_shift <= next_word;
               miso <= next_word[DATA_W-1];
               underrun <= ~shadow_full;
               if (shadow_full) shadow_full <= 1'b0;
            end
         end else if (ss_rise) begin
            miso <= 1'b0;
            bit_cnt <= '0;
            pending <= 1'b0;
            frame_abort <= bit_cnt != '0;
         end else begin
            if (s_rise) begin
               rx_shift <= {rx_shift[DATA_W-2:0], mosi_q};
               bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
               if (bit_cnt == LAST) begin
                  word_done <= 1'b1;
                  pending <= 1'b1;
               end
            end
            if (s_fall) begin
               if (pending) begin
                  pending <= 1'b0;
                  tx_shift <= next_word;
                  miso <= next_word[DATA_W-1];
                  underrun <= ~shadow_full;
                  if (shadow_full) shadow_full <= 1'b0;
               end else begin
                  tx_shift <= tx_shift << 1;
                  miso <= tx_shift[DATA_W-2];
               end
            end
         end
      end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bit-banged SPI master and tx host driving spi_slave, checked against a word-level model.
module tb_spi_slave;
   localparam int HALF = 40;
   localparam logic [7:0] DUMMY = 8'hFF;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
   logic miso, miso_oe, tx_ready, rx_valid, underrun, frame_abort, busy;
   logic [7:0] tx_data = '0, rx_data;
   logic tx_valid = 1'b0;
   int n_chk = 0, n_pass = 0, n_under = 0, n_abort = 0;
   logic [7:0] m_out[$], m_in[$], tx_q[$], rx_got[$];
   logic [7:0] last_rx = '0;

   spi_slave dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .underrun(underrun), .frame_abort(frame_abort), .busy(busy));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) rx_got.push_back(rx_data);
      if (underrun) n_under++;
      if (frame_abort) n_abort++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic load_tx(input logic [7:0] v);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_wait", tx_ready, 1);
      tx_data = v;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Mode-0 master: data set while sclk low, miso captured at each rise.
   // The frame closes with ss raised while sclk is still high.
   task automatic spi_frame(input int nbits);
      logic [7:0] cap = '0;
      #($urandom_range(0, 9));
      ss = 1'b0;
      #(2 * HALF);
      for (int i = 0; i < nbits; i++) begin
         mosi = m_out[i / 8][7 - (i % 8)];
         #HALF;
         cap = {cap[6:0], miso};
         sclk = 1'b1;
         if (i % 8 == 7) m_in.push_back(cap);
         if (i != nbits - 1) begin
            #HALF;
            sclk = 1'b0;
         end
      end
      #HALF;
      ss = 1'b1;
      #(HALF / 2);
      sclk = 1'b0;
      #(4 * HALF);
   endtask

   task automatic do_frame(input int nbytes, input int nload);
      int rx0, un0, ab0;
      rx0 = rx_got.size();
      un0 = n_under;
      ab0 = n_abort;
      m_in.delete();
      if (nload > 0) load_tx(tx_q[0]);
      fork
         spi_frame(8 * nbytes);
         begin
            for (int k = 1; k < nload; k++) load_tx(tx_q[k]);
         end
      join
      repeat (4) @(negedge clk);
      for (int k = 0; k < nbytes; k++) begin
         check("miso_word", m_in[k], k < nload ? tx_q[k] : DUMMY);
         check("rx_word", rx_got[rx0 + k], m_out[k]);
      end
      check("rx_count", rx_got.size() - rx0, nbytes);
      check("underrun_count", n_under - un0, nbytes - nload);
      check("abort_count", n_abort - ab0, 0);
      last_rx = m_out[nbytes - 1];
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rx0, ab0, total;
      #1 rst = 1'b1;
      #20;
      check("rst_miso", miso, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_data", rx_data, 0);
      check("rst_flags", {rx_valid, underrun, frame_abort, busy}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      m_out = '{8'h3C};
      tx_q = '{8'hA5};
      do_frame(1, 1);
      check("tx_ready_after", tx_ready, 1);

      m_out = '{8'hF0, 8'h0F};
      tx_q = '{8'h12, 8'h34};
      do_frame(2, 2);

      m_out = '{8'h55};
      tx_q.delete();
      do_frame(1, 0);

      m_out = '{8'h6B};
      load_tx(8'hC3);
      rx0 = rx_got.size();
      ab0 = n_abort;
      spi_frame(5);
      repeat (4) @(negedge clk);
      check("abort_pulse", n_abort - ab0, 1);
      check("abort_no_rx", rx_got.size() - rx0, 0);
      check("abort_rx_hold", rx_data, last_rx);
      m_out = '{8'($urandom)};
      tx_q = '{8'($urandom)};
      do_frame(1, 1);

      m_out = '{8'h9A};
      rx0 = rx_got.size();
      fork
         spi_frame(8);
         begin
            #(8 * HALF + 20);
            rst = 1'b1;
            #1;
            check("midrst_miso", miso, 0);
            check("midrst_oe", miso_oe, 0);
            check("midrst_ready", tx_ready, 1);
            check("midrst_rx_data", rx_data, 0);
            check("midrst_busy", busy, 0);
            #20;
            rst = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check("midrst_no_rx", rx_got.size() - rx0, 0);
      check("midrst_rx_hold", rx_data, 0);
      m_out = '{8'($urandom)};
      tx_q = '{8'($urandom)};
      do_frame(1, 1);

      total = 0;
      while (total < 100) begin
         int n;
         n = $urandom_range(1, 4);
         if (total + n > 100) n = 100 - total;
         m_out.delete();
         tx_q.delete();
         for (int k = 0; k < n; k++) begin
            m_out.push_back(8'($urandom));
            tx_q.push_back(8'($urandom));
         end
         do_frame(n, n);
         total += n;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0), MSB first; the peripheral-side counterpart of the team's SPI master.
- Oversamples the external sclk, ss and mosi pins in the clk domain.
- Delivers each received byte on a one-cycle valid strobe.
- Shifts out a byte the host loads through a valid/ready handshake.
- Supports multi-byte frames while ss is held low.

Parameters:
- DATA_W, 8: bits per transfer word.
- DUMMY, 8'hFF: word shifted out when no tx word is loaded at a word boundary.
- SYNC_STAGES, 2: flops in each pin synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst  input  1  reset.
- sclk  input  1  SPI clock from master, asynchronous to clk.
- ss  input  1  slave select, active low, asynchronous.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.
- miso_oe  output  1  miso output enable; high while the synchronized ss is low.
- tx_data  input  DATA_W  word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  tx shadow register empty.
- rx_data  output  DATA_W  last received word; held until the next word completes.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- underrun  output  1  one-clk pulse when DUMMY is loaded because the shadow was empty.
- frame_abort  output  1  one-clk pulse when ss rises with a partial word.
- busy  output  1  high in ACTIVE state.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0.
  - rx_valid=0, underrun=0, frame_abort=0, busy=0.
  - bit_cnt=0, state=IDLE, shadow empty.
  - Synchronizer flops reset so that ss=1 and sclk=0.
- Synchronization:
  - sclk, ss and mosi each pass through SYNC_STAGES flops.
  - One further flop per signal provides edge detection.
  - s_rise/s_fall are single-cycle pulses on synced sclk; ss_fall/ss_rise likewise on synced ss.
  - mosi is sampled from its synced copy, so it stays aligned with the synced sclk.
- TX handshake:
  - tx_valid && tx_ready in a cycle loads tx_data into the shadow; tx_ready drops the next cycle.
  - The shadow is consumed when it is moved into the tx shift register; tx_ready rises the cycle after.
  - tx_valid while tx_ready=0 is ignored; the host must hold tx_valid until it sees ready.
- States: IDLE, ACTIVE.
- IDLE:
  - On ss_fall, go to ACTIVE and clear bit_cnt.
  - Load the tx shift register from the shadow if full, else from DUMMY and pulse underrun.
  - miso is driven with the shift register MSB in the same cycle as the load, so the first bit is valid before the first sclk rise.
- ACTIVE, on s_rise:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_W-1 on this edge: next cycle rx_data <= completed word, rx_valid=1 for one cycle, bit_cnt wraps to 0.
  - Also set a pending-reload flag.
- ACTIVE, on s_fall:
  - If pending-reload is set, reload the tx shift register from the shadow (or DUMMY with an underrun pulse), clear the flag and drive the new MSB.
  - Otherwise shift the tx register left and drive the next bit.
- ACTIVE, on ss_rise:
  - Go to IDLE and drive miso to 0.
  - If bit_cnt != 0, pulse frame_abort and discard the partial rx_shift; rx_data is unchanged and there is no rx_valid.
  - A consumed shadow stays consumed. An unconsumed shadow is retained for the next frame.
- Simultaneous events:
  - ss_rise has priority over s_rise/s_fall in the same cycle.
  - A host load and a consumption in the same cycle are not possible: the load requires tx_ready=1, which means the shadow is empty.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pin.
- Reset mid-frame: all state returns to reset values immediately. A frame still in progress at the pins is ignored until ss has been seen high and then low again.
- IDLE ignores sclk edges.

Decomposition:
- Package spi_pkg (shared with the master) holds:
  - the slave state enum {IDLE, ACTIVE};
  - the DATA_W default constant;
  - the DUMMY default constant.
- Sub-module spi_pin_sync: SYNC_STAGES synchronizer plus edge detector with rise/fall pulse outputs. It is instantiated for sclk and ss; mosi uses the level output only.

Test Plan:
- Load tx 8'hA5, master sends 8'h3C in a single frame -> master receives 8'hA5; rx_data=8'h3C with exactly one rx_valid pulse; no underrun; tx_ready high again after the first reload.
- Two-byte frame with tx 8'h12 loaded, then 8'h34 loaded during byte 1; master sends 8'hF0, 8'h0F -> miso carries 8'h12, 8'h34; two rx_valid pulses with 8'hF0 then 8'h0F.
- No tx word loaded, master sends 8'h55 -> miso carries 8'hFF; underrun pulses once at ss_fall; rx_data=8'h55.
- ss rises after 5 sclk cycles -> frame_abort pulses once; no rx_valid; rx_data keeps its previous value; the next full frame receives correctly.
- rst asserted after 3 bits of a frame -> all outputs return to reset values; the remaining edges produce no rx_valid; the next frame works.
- sclk at clk/8 with a random pin phase offset, 100 random bytes in both directions -> all words match with no underrun or abort.
